// File: rtl/fft_pkg.sv
// Shared definitions for the FFT sequencer: state encoding and default sizes.
package fft_pkg;
   localparam int LOG2N_DEF = 4;
   localparam int N_DEF     = 1 << LOG2N_DEF;
   localparam int ADDR_W    = LOG2N_DEF;
   localparam int TW_W      = LOG2N_DEF - 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/fft_seq_ctrl_if.sv
// Control/address bundle between the FFT sequencer and its host/datapath.
interface fft_seq_ctrl_if import fft_pkg::*; #(
   parameter int LOG2N = LOG2N_DEF
) ();
   logic             start_i;
   logic             busy_o;
   logic             done_o;
   logic [LOG2N-1:0] stage_o;
   logic             rd_en_o;
   logic [LOG2N-1:0] rd_addr_a_o;
   logic [LOG2N-1:0] rd_addr_b_o;
   logic [LOG2N-2:0] tw_idx_o;
   logic             wr_en_o;
   logic [LOG2N-1:0] wr_addr_a_o;
   logic [LOG2N-1:0] wr_addr_b_o;

   modport master (
      output start_i,
      input  busy_o, done_o, stage_o, rd_en_o, rd_addr_a_o, rd_addr_b_o,
             tw_idx_o, wr_en_o, wr_addr_a_o, wr_addr_b_o
   );

   modport slave (
      input  start_i,
      output busy_o, done_o, stage_o, rd_en_o, rd_addr_a_o, rd_addr_b_o,
             tw_idx_o, wr_en_o, wr_addr_a_o, wr_addr_b_o
   );
endinterface

// File: rtl/fft_wb_delay.sv
// Fixed-depth shift register that carries issue valid + addresses to write-back.
module fft_wb_delay import fft_pkg::*; #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 1 + 2*ADDR_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   logic [DEPTH-1:0][WIDTH-1:0] pipe;

   // Shift one stage per cycle; reset empties the whole line so nothing is written.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pipe <= '0;
      end else begin
         pipe[0] <= din;
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign dout = pipe[DEPTH-1];
endmodule

// File: rtl/fft_seq_ctrl.sv
// Radix-2 DIT in-place FFT sequencer: issues N/2 butterflies per stage,
// drains the butterfly latency between stages, and pulses done at the end.
module fft_seq_ctrl import fft_pkg::*; #(
   parameter int LOG2N  = LOG2N_DEF,
   parameter int BF_LAT = 2
) (
   input logic           clk_i,
   input logic           rst_i,
   fft_seq_ctrl_if.slave bus
);
   localparam int AW  = LOG2N;
   localparam int TWW = LOG2N - 1;
   localparam int KW  = LOG2N - 1;
   localparam int DW  = 1 + 2*AW;

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_RUN   = ST_RUN;
   localparam logic [1:0] S_DRAIN = ST_DRAIN;
   localparam logic [1:0] S_DONE  = ST_DONE;

   localparam logic [KW-1:0] K_LAST = '1;
   localparam logic [AW-1:0] S_LAST = AW'(LOG2N - 1);
   localparam logic [3:0]    D_LAST = 4'(BF_LAT - 1);

   logic [1:0]     state;
   logic [AW-1:0]  s;
   logic [KW-1:0]  k;
   logic [3:0]     dcnt;

   logic           rd_en;
   logic [AW-1:0]  span, pos, grp, a, b, tw_sh;
   logic [TWW-1:0] tw;
   logic [AW-1:0]  a_q, b_q;
   logic [DW-1:0]  wb_in, wb_out;

   // Sequencer FSM: stage/butterfly counters and the inter-stage drain timer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= S_IDLE;
         s     <= '0;
         k     <= '0;
         dcnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start_i) begin
                  state <= S_RUN;
                  s     <= '0;
                  k     <= '0;
               end
            end
            S_RUN: begin
               if (k == K_LAST) begin
                  state <= S_DRAIN;
                  dcnt  <= '0;
               end else begin
                  k <= k + KW'(1);
               end
            end
            S_DRAIN: begin
               if (dcnt == D_LAST) begin
                  if (s == S_LAST) begin
                     state <= S_DONE;
                  end else begin
                     state <= S_RUN;
                     s     <= s + AW'(1);
                     k     <= '0;
                  end
               end else begin
                  dcnt <= dcnt + 4'd1;
               end
            end
            default: begin
               state <= S_IDLE;
               s     <= '0;
               k     <= '0;
            end
         endcase
      end
   end

   // Butterfly addressing: split k into group and position within the span.
   always_comb begin
      span  = AW'(1) << s;
      pos   = AW'(k) & (span - AW'(1));
      grp   = AW'(k) >> s;
      a     = ((grp << s) << 1) | pos;
      b     = a | span;
      tw_sh = AW'(LOG2N - 1) - s;
      tw    = TWW'(pos << tw_sh);
   end

   assign rd_en = (state == S_RUN);
   assign a_q   = rd_en ? a : '0;
   assign b_q   = rd_en ? b : '0;

   assign bus.busy_o      = (state != S_IDLE);
   assign bus.done_o      = (state == S_DONE);
   assign bus.stage_o     = s;
   assign bus.rd_en_o     = rd_en;
   assign bus.rd_addr_a_o = a_q;
   assign bus.rd_addr_b_o = b_q;
   assign bus.tw_idx_o    = rd_en ? tw : '0;

   assign wb_in = {rd_en, a_q, b_q};

   fft_wb_delay #(
      .DEPTH (BF_LAT),
      .WIDTH (DW)
   ) u_wb_delay (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .din   (wb_in),
      .dout  (wb_out)
   );

   assign bus.wr_en_o     = wb_out[DW-1];
   assign bus.wr_addr_a_o = wb_out[2*AW-1:AW];
   assign bus.wr_addr_b_o = wb_out[AW-1:0];
endmodule

// File: doc/fft_seq_ctrl.md
FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 SHALL have parameter LOG2N, default 4, meaning log2 of transform size (N = 16).
REQ-002 SHALL have parameter BF_LAT, default 2, meaning cycles from issue to write-back (memory read plus butterfly), legal range 1..8.
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, meaning the reset, which is synchronous and active-high.
REQ-005 SHALL have port start_i, input, 1, meaning a one-cycle request to run one full in-place FFT.
REQ-006 SHALL have port busy_o, output, 1, meaning a transform is in progress.
REQ-007 SHALL have port done_o, output, 1, meaning a one-cycle pulse when the transform is complete.
REQ-008 SHALL have port stage_o, output, LOG2N bits, meaning the current issue stage.
REQ-009 SHALL have port rd_en_o, output, 1, meaning a butterfly issue this cycle.
REQ-010 SHALL have ports rd_addr_a_o and rd_addr_b_o, output, LOG2N bits each, meaning the A and B operand addresses.
REQ-011 SHALL have port tw_idx_o, output, LOG2N-1 bits, meaning the twiddle ROM index k for W_N^k.
REQ-012 SHALL have port wr_en_o, output, 1, meaning butterfly results are to be written this cycle.
REQ-013 SHALL have ports wr_addr_a_o and wr_addr_b_o, output, LOG2N bits each, meaning the A' and B' write-back addresses.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-015 SHALL transition IDLE->RUN on start_i, and SHALL ignore start_i in every other state.
REQ-016 SHALL issue, in RUN, one butterfly per cycle with butterfly counter k = 0..N/2-1; the first issue occurs in the cycle after start_i.
REQ-017 SHALL compute addresses for stage s as: span = 2^s; pos = k mod span; grp = k >> s; a = grp*2*span + pos; b = a + span; tw = pos << (LOG2N-1-s). The data is assumed bit-reversed on load (radix-2 DIT).
REQ-018 SHALL go RUN->DRAIN after k = N/2-1 and SHALL hold DRAIN for exactly BF_LAT cycles with rd_en_o=0, so the first read of stage s+1 occurs the cycle after the last write of stage s.
REQ-019 SHALL go DRAIN->RUN with s+1 and k=0 when s < LOG2N-1, and SHALL otherwise go DRAIN->DONE.
REQ-020 SHALL assert done_o in DONE for one cycle, then return to IDLE; done_o therefore pulses the cycle after the final wr_en_o.
REQ-021 SHALL produce wr_en_o and wr_addr_a_o/wr_addr_b_o as rd_en_o and rd_addr_a_o/rd_addr_b_o delayed by exactly BF_LAT cycles.
REQ-022 SHALL hold busy_o at 1 in RUN, DRAIN and DONE, and at 0 in IDLE.
REQ-023 SHALL make stage_o track s and hold it through DRAIN.
REQ-024 SHALL take total latency from start_i to done_o of LOG2N*(N/2+BF_LAT)+1 cycles, which is 41 for the defaults.
REQ-025 SHALL drive address and tw_idx_o outputs to 0 when rd_en_o=0.

Reset
REQ-026 SHALL, on rst_i, force state to IDLE and set s=0, k=0, and clear every delay-line valid and address stage.
REQ-027 SHALL reset every output to 0 (busy_o, done_o, rd_en_o, wr_en_o, all addresses, tw_idx_o, stage_o).
REQ-028 SHALL, on rst_i mid-transform, abort with no further wr_en_o pulses and no done_o pulse; rst_i SHALL take priority over start_i in the same cycle.

Structure
REQ-029 SHALL place the state enum, the LOG2N/N defaults and the address/twiddle-width localparams in a shared package fft_pkg.
REQ-030 SHALL implement the write-back delay line as sub-module fft_wb_delay, parameterised by depth BF_LAT and width 1+2*LOG2N.

Verification
REQ-031 SHALL verify: defaults, start_i at cycle 0 -> rd_en_o at cycle 1 with a=0, b=1, tw=0, stage_o=0.
REQ-032 SHALL verify: stage 1, k=1 -> a=1, b=3, tw=4; stage 2, k=5 -> a=9, b=13, tw=2; stage 3, k=7 -> a=7, b=15, tw=7.
REQ-033 SHALL verify: full run -> 32 wr_en_o pulses, each matching its issue address BF_LAT cycles earlier, with a 2-cycle rd_en_o gap between stages and done_o at cycle 41.
REQ-034 SHALL verify: start_i pulsed at cycle 10 during RUN -> no effect, done_o still at cycle 41 only.
REQ-035 SHALL verify: rst_i at cycle 15 -> all outputs 0 at cycle 16, no done_o; a fresh start_i then completes normally.
REQ-036 SHALL verify: BF_LAT=1 -> DRAIN is 1 cycle and done_o arrives 37 cycles after start_i.
